mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, word-address width (3-bit tag + 10-bit index + 2-bit word offset).
REQ-002 SHALL have parameter DATA_W, default 32, word width.
REQ-003 SHALL have parameter LATENCY, default 4, access latency in cycles; legal range 1..15.
REQ-004 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  input  1  cache presents a request.
REQ-007 SHALL have port req_we  input  1  1 = single-word write, 0 = 4-word block read.
REQ-008 SHALL have port req_adr  input  ADDR_W  word address; bits [1:0] are ignored for reads.
REQ-009 SHALL have port req_wdata  input  DATA_W  write data.
REQ-010 SHALL have port req_ready  output  1  responder can accept a request.
REQ-011 SHALL have port rdata  output  DATA_W  registered read beat data.
REQ-012 SHALL have port rdata_valid  output  1  rdata carries a beat.
REQ-013 SHALL have port rdata_last  output  1  marks beat 3 of a burst.
REQ-014 SHALL have port wr_ack  output  1  one-cycle write-completion pulse.
REQ-015 SHALL have port read_count  output  16  saturating count of completed block reads.
REQ-016 SHALL have port write_count  output  16  saturating count of completed writes.

Function
REQ-017 SHALL use a state machine with states IDLE, WAIT, BURST, WACK.
REQ-018 SHALL drive req_ready high only in IDLE; a request is accepted on an edge where req_valid and req_ready are both high.
REQ-019 SHALL capture req_we, req_adr and req_wdata at acceptance; later input changes SHALL have no effect until the next acceptance.
REQ-020 SHALL, on acceptance, enter WAIT and load a latency counter so the first response cycle is exactly LATENCY cycles after the accepting edge.
REQ-021 SHALL, for a read, assert rdata_valid on 4 consecutive cycles carrying words {adr[ADDR_W-1:2], 2'b00..2'b11} in ascending order, with rdata_last high on the fourth beat only.
REQ-022 SHALL, for a write, update the array at the captured address and pulse wr_ack for exactly one cycle, LATENCY cycles after acceptance.
REQ-023 SHALL return to IDLE with req_ready high on the cycle after the last beat or after wr_ack.
REQ-024 SHALL make a completed write visible to every later read of the same word.
REQ-025 SHALL increment read_count on the rdata_last cycle and write_count on the wr_ack cycle, each holding at 16'hFFFF.
REQ-026 SHALL keep rdata_valid, rdata_last and wr_ack low outside their response cycles; rdata value outside valid beats is don't-care.
REQ-027 SHALL hold at most one outstanding request; back-to-back requests are separated by at least one IDLE cycle.
REQ-028 SHALL leave array contents unaffected by reset; initial contents come from a hex file loaded at time zero.

Reset
REQ-029 SHALL, while rst is high at an edge, force state IDLE, latency counter 0, req_ready 1, rdata_valid 0, rdata_last 0, wr_ack 0, read_count 0, write_count 0, rdata 0.
REQ-030 SHALL, on reset mid-WAIT or mid-BURST, abandon the request with no further beats, no array write and no counter increment.

Structure
REQ-031 SHALL place ADDR_W, DATA_W, BLOCK_WORDS (4) and the state encodings in a shared package used with cache_controller.
REQ-032 SHALL implement storage in one sub-module mem_array: 2**ADDR_W x DATA_W, synchronous write, registered read.

Verification
REQ-033 SHALL test read: preload words 0x40..0x43 with 0xA0..0xA3, read adr 0x41 -> beats 0xA0,0xA1,0xA2,0xA3 starting 4 cycles after acceptance, last on 0xA3, read_count=1.
REQ-034 SHALL test write-then-read: write 0xDEADBEEF to 0x1234, wr_ack after 4 cycles; read 0x1234 -> beat 0 = 0xDEADBEEF.
REQ-035 SHALL test request hold-off: req_valid held high through a burst -> no second acceptance until the cycle after rdata_last; input changes mid-burst do not alter beats.
REQ-036 SHALL test reset during beat 1 of a burst -> no further rdata_valid; req_ready=1 the cycle after reset; read_count=0.
REQ-037 SHALL test LATENCY=1 -> first beat on the cycle immediately after acceptance.
REQ-038 SHALL test saturation: 65536 writes -> write_count holds 16'hFFFF.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
//   Shared definitions for the backing-memory responder and its cache-side
//   peer (cache_controller): address/data geometry, refill block size, the
//   responder state encoding and a saturating-counter helper.
// -----------------------------------------------------------------------------
package mem_responder_pkg;

   // Word address: 3-bit tag + 10-bit index + 2-bit word offset.
   localparam int ADDR_W      = 15;
   localparam int DATA_W      = 32;
   // Words returned per block read (one cache line).
   localparam int BLOCK_WORDS = 4;

   localparam int              CNT_W   = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // IDLE  : ready for a request
   // WAIT  : access latency countdown
   // BURST : one read beat visible per cycle
   // WACK  : write-completion pulse cycle
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      BURST = 2'd2,
      WACK  = 2'd3
   } state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mem_responder_array.sv
// -----------------------------------------------------------------------------
// mem_array
//   2**ADDR_W x DATA_W storage with a synchronous write port and a registered
//   read port. Contents are never reset; only the read register is cleared by
//   rst so the responder's rdata output starts at zero.
//
// Ports
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset (read register only)
//   we     : write enable, wdata stored at waddr on the edge
//   waddr  : write word address
//   wdata  : write data
//   re     : read enable, mem[raddr] loaded into rdata on the edge
//   raddr  : read word address
//   rdata  : registered read data
// -----------------------------------------------------------------------------
module mem_array #(
   parameter int ADDR_W = mem_responder_pkg::ADDR_W,
   parameter int DATA_W = mem_responder_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Backing memory for a cache. Accepts one request at a time: a single-word
//   write or a 4-word block read. The response starts LATENCY clock edges after
//   the accepting edge. Reads return the aligned block in ascending word order,
//   one beat per cycle, with rdata_last on the fourth beat. Writes commit to the
//   array and pulse wr_ack for one cycle. Saturating counters track completed
//   reads and writes.
//
// Parameters
//   ADDR_W  : word-address width
//   DATA_W  : word width
//   LATENCY : accepting edge to first response edge, 1..15
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake, transfer when both high at an edge
//   req_we                : 1 = single-word write, 0 = block read
//   req_adr               : word address (bits [1:0] ignored for reads)
//   req_wdata             : write data
//   rdata                 : registered read beat data
//   rdata_valid           : rdata carries a beat
//   rdata_last            : final beat of a block
//   wr_ack                : one-cycle write completion
//   read_count            : completed block reads, saturating
//   write_count           : completed writes, saturating
// -----------------------------------------------------------------------------
module mem_responder #(
   parameter int ADDR_W  = mem_responder_pkg::ADDR_W,
   parameter int DATA_W  = mem_responder_pkg::DATA_W,
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_adr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              rdata_last,
   output logic              wr_ack,
   output logic [15:0]       read_count,
   output logic [15:0]       write_count
);

   import mem_responder_pkg::*;

   // The counter is loaded with LATENCY-1 on acceptance; the edge that sees it
   // at zero is the LATENCY-th edge and launches the response.
   localparam logic [3:0] LAT_LOAD  = 4'(LATENCY - 1);
   localparam logic [1:0] LAST_BEAT = 2'(BLOCK_WORDS - 1);

   state_t            state_q, state_d;
   logic [3:0]        lat_q, lat_d;
   logic [1:0]        beat_q, beat_d;
   logic              we_q;
   logic [ADDR_W-1:0] adr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [15:0]       rd_cnt_q, wr_cnt_q;

   logic              capture;
   logic              mem_we, mem_re;
   logic              mem_wr_gated;
   logic [1:0]        rd_word;
   logic              rd_inc, wr_inc;
   logic [ADDR_W-1:0] mem_raddr;

   // ---------------------------------------------------------------------------
   // Next-state logic. beat_q is the index of the beat currently on rdata while
   // in BURST; the array read for the following beat is issued on the same edge
   // that makes the current beat visible, so rdata lines up with rdata_valid.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      beat_d  = beat_q;
      capture = 1'b0;
      mem_we  = 1'b0;
      mem_re  = 1'b0;
      rd_word = 2'd0;
      rd_inc  = 1'b0;
      wr_inc  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               capture = 1'b1;
               lat_d   = LAT_LOAD;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (lat_q != 4'd0) begin
               lat_d = lat_q - 4'd1;
            end else if (we_q) begin
               mem_we  = 1'b1;
               wr_inc  = 1'b1;
               state_d = WACK;
            end else begin
               mem_re  = 1'b1;
               rd_word = 2'd0;
               beat_d  = 2'd0;
               state_d = BURST;
            end
         end
         BURST: begin
            if (beat_q == LAST_BEAT) begin
               state_d = IDLE;
            end else begin
               mem_re  = 1'b1;
               rd_word = beat_q + 2'd1;
               beat_d  = rd_word;
               // Count the read on the edge that exposes rdata_last.
               rd_inc  = (rd_word == LAST_BEAT);
            end
         end
         WACK: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         lat_q    <= '0;
         beat_q   <= '0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         beat_q  <= beat_d;
         if (rd_inc) begin
            rd_cnt_q <= sat_inc(rd_cnt_q);
         end
         if (wr_inc) begin
            wr_cnt_q <= sat_inc(wr_cnt_q);
         end
      end
   end

   // Request fields are held from acceptance until the next acceptance.
   always_ff @(posedge clk) begin
      if (capture) begin
         we_q    <= req_we;
         adr_q   <= req_adr;
         wdata_q <= req_wdata;
      end
   end

   // A reset landing on the commit edge must abandon the write.
   assign mem_wr_gated = mem_we && !rst;
   assign mem_raddr    = {adr_q[ADDR_W-1:2], rd_word};

   mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (mem_wr_gated),
      .waddr (adr_q),
      .wdata (wdata_q),
      .re    (mem_re),
      .raddr (mem_raddr),
      .rdata (rdata)
   );

   assign req_ready   = (state_q == IDLE);
   assign rdata_valid = (state_q == BURST);
   assign rdata_last  = (state_q == BURST) && (beat_q == LAST_BEAT);
   assign wr_ack      = (state_q == WACK);
   assign read_count  = rd_cnt_q;
   assign write_count = wr_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Two responders share one stimulus bus: dut (LATENCY=4) and dut1
//   (LATENCY=1); `sel` routes req_valid to one of them and muxes its outputs
//   back. Expected data comes from a word-addressed associative-array model of
//   memory plus a beat queue; expected counters are plain saturating integers.
// -----------------------------------------------------------------------------
module tb_mem_responder;

   localparam int AW = 15;
   localparam int DW = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          req_valid = 1'b0;
   logic          req_we    = 1'b0;
   logic [AW-1:0] req_adr   = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          sel       = 1'b0;

   logic          rdy0, rdv0, last0, ack0, rdy1, rdv1, last1, ack1;
   logic [DW-1:0] rd0, rd1;
   logic [15:0]   rc0, wc0, rc1, wc1;

   mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(4)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_we(req_we),
      .req_adr(req_adr), .req_wdata(req_wdata), .req_ready(rdy0), .rdata(rd0),
      .rdata_valid(rdv0), .rdata_last(last0), .wr_ack(ack0),
      .read_count(rc0), .write_count(wc0)
   );

   mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_we(req_we),
      .req_adr(req_adr), .req_wdata(req_wdata), .req_ready(rdy1), .rdata(rd1),
      .rdata_valid(rdv1), .rdata_last(last1), .wr_ack(ack1),
      .read_count(rc1), .write_count(wc1)
   );

   wire          rdy  = sel ? rdy1  : rdy0;
   wire          rdv  = sel ? rdv1  : rdv0;
   wire          last = sel ? last1 : last0;
   wire          ack  = sel ? ack1  : ack0;
   wire [DW-1:0] rd   = sel ? rd1   : rd0;
   wire [15:0]   rc   = sel ? rc1   : rc0;
   wire [15:0]   wc   = sel ? wc1   : wc0;

   // ---------------- reference model / scoreboard ----------------
   int            vectors     = 0;
   int            miscompares = 0;
   logic [DW-1:0] mem_m [int];
   logic [DW-1:0] exp_q [$];
   logic [15:0]   exp_rc [2];
   logic [15:0]   exp_wc [2];

   function automatic int lat();
      return sel ? 1 : 4;
   endfunction

   function automatic int key(input logic [AW-1:0] a);
      return (sel ? 32768 : 0) + int'(a);
   endfunction

   function automatic logic [15:0] sat(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks (enter and leave at a negedge) ----------------
   task automatic scramble();
      req_we    = 1'($urandom_range(0, 1));
      req_adr   = AW'($urandom);
      req_wdata = $urandom;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (rdy !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("ready_timeout", rdy, 1);
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      int k;
      wait_ready();
      req_valid = 1'b1; req_we = 1'b1; req_adr = a; req_wdata = d;
      @(negedge clk);
      req_valid = 1'b0;
      scramble();
      k = 0;
      while (ack !== 1'b1 && k < 40) begin
         chk("wr_busy_ready", rdy, 0);
         @(negedge clk);
         k++;
      end
      chk("wr_latency", k, lat());
      chk("wr_ack_ready", rdy, 0);
      mem_m[key(a)] = d;
      exp_wc[sel]   = sat(exp_wc[sel]);
      chk("write_count", wc, exp_wc[sel]);
      @(negedge clk);
      chk("wr_ack_pulse", ack, 0);
      chk("wr_idle_ready", rdy, 1);
   endtask

   task automatic do_read(input logic [AW-1:0] a, input bit hold);
      int k;
      logic [AW-1:0] wa;
      wait_ready();
      req_valid = 1'b1; req_we = 1'b0; req_adr = a; req_wdata = $urandom;
      for (int j = 0; j < 4; j++) begin
         wa = {a[AW-1:2], 2'(j)};
         exp_q.push_back(mem_m[key(wa)]);
      end
      @(negedge clk);
      req_valid = hold;
      scramble();
      k = 0;
      while (rdv !== 1'b1 && k < 40) begin
         chk("rd_busy_ready", rdy, 0);
         @(negedge clk);
         scramble();
         k++;
      end
      chk("rd_latency", k, lat());
      for (int j = 0; j < 4; j++) begin
         chk("rd_beat_valid", rdv, 1);
         chk("rd_beat_data", rd, exp_q.pop_front());
         chk("rd_beat_last", last, (j == 3));
         chk("rd_beat_ready", rdy, 0);
         if (j == 3) begin
            exp_rc[sel] = sat(exp_rc[sel]);
            chk("read_count", rc, exp_rc[sel]);
         end
         @(negedge clk);
         scramble();
      end
      chk("rd_done_valid", rdv, 0);
      chk("rd_done_ready", rdy, 1);
      req_valid = 1'b0;
   endtask

   task automatic model_reset();
      exp_rc[0] = '0; exp_rc[1] = '0;
      exp_wc[0] = '0; exp_wc[1] = '0;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int k;
      model_reset();

      // Reset state, sampled while rst is still high.
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", rdy0, 1);
      chk("rst_valid", rdv0, 0);
      chk("rst_last", last0, 0);
      chk("rst_ack", ack0, 0);
      chk("rst_rdata", rd0, 0);
      chk("rst_rc", rc0, 0);
      chk("rst_wc", wc0, 0);
      rst = 1'b0;
      @(negedge clk);

      // Preload 0x40..0x43 and read the block through an unaligned address.
      for (int i = 0; i < 4; i++) do_write(AW'(16'h40 + i), 32'hA0 + i);
      do_read(15'h41, 1'b0);

      // Write then read back.
      do_write(15'h1234, 32'hDEADBEEF);
      for (int i = 1; i < 4; i++) do_write(AW'(16'h1234 + i), $urandom);
      do_read(15'h1234, 1'b0);

      // Random traffic over a 32-word region, prefilled so every read is known.
      for (int i = 0; i < 32; i++) do_write(AW'(16'h100 + i), $urandom);
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 1) == 1)
            do_write(AW'(16'h100 + $urandom_range(0, 31)), $urandom);
         else
            do_read(AW'(16'h100 + $urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end

      // req_valid held through a burst with inputs churning; the next request
      // follows right after the last beat.
      do_read(15'h40, 1'b1);
      do_read(15'h43, 1'b0);

      // Reset while beat 1 is on the bus.
      wait_ready();
      req_valid = 1'b1; req_we = 1'b0; req_adr = 15'h40;
      @(negedge clk);
      req_valid = 1'b0;
      k = 0;
      while (rdv0 !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      chk("rstb_beat1_valid", rdv0, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      chk("rstb_ready", rdy0, 1);
      chk("rstb_valid", rdv0, 0);
      chk("rstb_rc", rc0, 0);
      chk("rstb_rdata", rd0, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rstb_no_beat", rdv0, 0);
         chk("rstb_no_last", last0, 0);
      end
      chk("rstb_rc_after", rc0, 0);

      // Reset while a write to 0x41 is waiting: the array keeps its old word.
      req_valid = 1'b1; req_we = 1'b1; req_adr = 15'h41; req_wdata = 32'h5555AAAA;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rstw_no_ack", ack0, 0);
      end
      chk("rstw_wc", wc0, 0);
      do_read(15'h40, 1'b0);

      // LATENCY=1 instance: response on the first edge after acceptance.
      sel = 1'b1;
      for (int i = 0; i < 4; i++) do_write(AW'(16'h200 + i), $urandom);
      do_read(15'h202, 1'b0);
      do_read(15'h200, 1'b1);
      sel = 1'b0;

      // Saturation: start the write counter just below the top, then write on.
      force dut.wr_cnt_q = 16'hFFFB;
      @(negedge clk);
      release dut.wr_cnt_q;
      exp_wc[0] = 16'hFFFB;
      for (int i = 0; i < 7; i++) do_write(AW'(16'h300 + i), $urandom);
      chk("wc_saturated", wc0, 16'hFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
